comparator_trigger_conditioner: RTL



---
 rtl/trig_pkg.sv | 17 +
 rtl/sync_glitch_filter.sv | 48 ++++
 rtl/comparator_trigger_conditioner.sv | 114 +++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared FSM state type and counter helpers for the comparator trigger conditioner
package trig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

    localparam int CNT_WIDTH_DEF = 24;

    // All-ones value of a w-bit counter.
    function automatic logic [63:0] cnt_sat(input int w);
        return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// sync_glitch_filter: synchronises an async input, suppresses short pulses and flags rising edges
//   clk, rst : clock, synchronous active-high reset
//   sig_in   : asynchronous input
//   sig_out  : synchronised, filtered level
//   rising   : one-cycle pulse in the first cycle sig_out is high
module sync_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_out,
    output logic rising
);

    localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // The filtered level only follows after FILTER_LEN consecutive differing samples;
    // rising is registered together with the level change so both appear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            filt_cnt <= '0;
            sig_out  <= 1'b0;
            rising   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            rising <= 1'b0;
            if (synced == sig_out) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                sig_out  <= synced;
                rising   <= synced;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/comparator_trigger_conditioner.sv
// comparator_trigger_conditioner: conditions a comparator square wave and flags when its frequency is stable
//   clk, rst        : clock, synchronous active-high reset
//   comp_in         : asynchronous comparator square wave
//   en              : enables period measurement and stability tracking
//   sync_signal_out : synchronised, filtered square wave
//   signal_rising   : one-cycle pulse on each rising edge of sync_signal_out
//   period          : last measured period in clk cycles
//   period_valid    : one-cycle pulse when period updates
//   stable          : successive periods agree within TOL
//   timeout         : one-cycle pulse when the period counter saturates without an edge
module comparator_trigger_conditioner
    import trig_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int TOL         = 16,
    parameter int MIN_PERIOD  = 8,
    parameter int STABLE_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 comp_in,
    input  logic                 en,
    output logic                 sync_signal_out,
    output logic                 signal_rising,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 stable,
    output logic                 timeout
);

    localparam int                   MW      = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_sat(CNT_WIDTH));

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt, prev, diff;
    logic [MW-1:0]        match_cnt, match_nxt;
    logic                 has_prev, match;

    sync_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .sig_in (comp_in),
        .sig_out(sync_signal_out),
        .rising (signal_rising)
    );

    // Larger minus smaller so the difference never wraps.
    assign diff      = cnt > prev ? cnt - prev : prev - cnt;
    assign match     = diff <= CNT_WIDTH'(TOL) && cnt >= CNT_WIDTH'(MIN_PERIOD);
    assign match_nxt = !match ? '0 : match_cnt == MW'(STABLE_CNT) ? match_cnt : match_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            prev         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stable       <= 1'b0;
            timeout      <= 1'b0;
            match_cnt    <= '0;
            has_prev     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                stable    <= 1'b0;
                match_cnt <= '0;
                has_prev  <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_EDGE;
                    WAIT_EDGE: begin
                        if (signal_rising) begin
                            cnt      <= CNT_WIDTH'(1);
                            has_prev <= 1'b0;
                            state    <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // An edge coinciding with saturation is still a valid measurement.
                        if (signal_rising) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            prev         <= cnt;
                            cnt          <= CNT_WIDTH'(1);
                            has_prev     <= 1'b1;
                            if (has_prev) begin
                                match_cnt <= match_nxt;
                                stable    <= match_nxt == MW'(STABLE_CNT);
                            end
                        end else if (cnt == CNT_MAX) begin
                            timeout   <= 1'b1;
                            stable    <= 1'b0;
                            match_cnt <= '0;
                            has_prev  <= 1'b0;
                            state     <= WAIT_EDGE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
